// File: rtl/conv2d_pkg.sv
// Shared types, constants and arithmetic helpers for the streaming 3x3 convolution core.
package conv2d_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int WIN       = 3;
  localparam int NTAPS     = 9;
  localparam int BIAS_ADDR = 9;
  localparam int SAT_W     = 128;

  function automatic int acc_w(input int dwidth);
    return 2 * dwidth + 4;
  endfunction

  // Clamp a wide signed value into a dwidth-bit signed range, then optionally zero negatives.
  function automatic logic signed [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] val,
                                                       input int dwidth, input logic relu);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    hi  = (SAT_W'(1) <<< (dwidth - 1)) - SAT_W'(1);
    lo  = -hi - SAT_W'(1);
    res = val;
    if (val > hi) res = hi;
    else if (val < lo) res = lo;
    if (relu && res[SAT_W-1]) res = '0;
    return res;
  endfunction

endpackage

// File: rtl/core_featuremap_conv2d_mac9.sv
// Two-stage multiply/accumulate: nine registered products, then adder tree plus scaled bias.
module conv2d_mac9
  import conv2d_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 16,
  parameter int ACC_W  = acc_w(DWIDTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [NTAPS*DWIDTH-1:0]   win_px,
  input  logic [NTAPS*DWIDTH-1:0]   taps,
  input  logic [DWIDTH-1:0]         bias,
  output logic                      stage1_valid,
  output logic                      sum_valid,
  output logic [ACC_W-1:0]          sum
);

  localparam int PW = 2 * DWIDTH;

  logic signed [PW-1:0]    prod_q [NTAPS];
  logic signed [PW-1:0]    prod_d [NTAPS];
  logic signed [ACC_W-1:0] bias_q, bias_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    v1_q, v1_d, v2_q, v2_d;

  always_comb begin
    logic [DWIDTH-1:0] a, b;
    logic [PW-1:0]     a_ext, b_ext;
    a      = '0;
    b      = '0;
    a_ext  = '0;
    b_ext  = '0;
    prod_d = prod_q;
    bias_d = bias_q;
    v1_d   = v1_q;
    if (en) begin
      v1_d = in_valid;
      for (int i = 0; i < NTAPS; i++) begin
        a         = win_px[i*DWIDTH +: DWIDTH];
        b         = taps[i*DWIDTH +: DWIDTH];
        a_ext     = {{DWIDTH{a[DWIDTH-1]}}, a};
        b_ext     = {{DWIDTH{b[DWIDTH-1]}}, b};
        prod_d[i] = a_ext * b_ext;
      end
      bias_d = $signed({{(ACC_W-DWIDTH){bias[DWIDTH-1]}}, bias}) <<< FRAC;
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] acc;
    acc   = bias_q;
    sum_d = sum_q;
    v2_d  = v2_q;
    for (int i = 0; i < NTAPS; i++)
      acc = acc + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
    if (en) begin
      v2_d  = v1_q;
      sum_d = acc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_q <= '{default: '0};
      bias_q <= '0;
      sum_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      prod_q <= prod_d;
      bias_q <= bias_d;
      sum_q  <= sum_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
    end
  end

  assign stage1_valid = v1_q;
  assign sum_valid    = v2_q;
  assign sum          = sum_q;

endmodule

// File: rtl/core_featuremap_conv2d_param.sv
// Streaming 3x3 convolution: FIFO-fed column window, loadable kernel, saturating output stage.
// state   | meaning
// S_IDLE  | waiting for start; weight writes accepted
// S_RUN   | popping input columns until the frame's last column
// S_DRAIN | no more pops; flushing the pipeline into the output FIFO
// S_DONE  | one-cycle done pulse
module core_featuremap_conv2d_param
  import conv2d_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 62
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3*DWIDTH-1:0]   ff_rdata,
  output logic                  ff_rdreq,
  input  logic                  ff_empty,
  output logic [DWIDTH-1:0]     ff_wdata,
  output logic                  ff_wrreq,
  input  logic                  ff_full,
  input  logic                  wt_we,
  input  logic [3:0]            wt_addr,
  input  logic [DWIDTH-1:0]     wt_wdata,
  input  logic                  relu_en,
  input  logic                  start,
  output logic                  busy,
  output logic                  done
);

  localparam int ACC_W = acc_w(DWIDTH);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  state_e                state_q, state_d;
  logic                  busy_q, done_q, relu_q, relu_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [3*DWIDTH-1:0]   win_q [WIN];
  logic [3*DWIDTH-1:0]   win_d [WIN];
  logic                  v0_q, v0_d;
  logic [DWIDTH-1:0]     wt_q [NTAPS+1];
  logic [DWIDTH-1:0]     wt_d [NTAPS+1];
  logic [DWIDTH-1:0]     out_q, out_d;
  logic                  out_valid_q, out_valid_d;

  logic                      advance, pop, last_pop, drain_empty, start_frame;
  logic [NTAPS*DWIDTH-1:0]   win_px, tap_vec;
  logic                      mac_v1, mac_v2;
  logic signed [ACC_W-1:0]   mac_sum, shifted;
  logic signed [SAT_W-1:0]   sat_val;

  assign advance     = ~out_valid_q | ~ff_full;
  assign pop         = (state_q == S_RUN) & ~ff_empty & advance;
  assign last_pop    = pop & (col_q == LAST_COL) & (row_q == LAST_ROW);
  assign drain_empty = ~v0_q & ~mac_v1 & ~mac_v2 & (~out_valid_q | ~ff_full);
  assign start_frame = (state_q == S_IDLE) & start;

  always_comb begin
    state_d = state_q;
    relu_d  = relu_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        relu_d  = relu_en;
      end
      S_RUN:   if (last_pop) state_d = S_DRAIN;
      S_DRAIN: if (drain_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      relu_q  <= relu_d;
    end
  end

  // Leftmost kernel column sits in the oldest window slot.
  always_comb begin
    win_px  = '0;
    tap_vec = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        win_px[(r*WIN+c)*DWIDTH +: DWIDTH] = win_q[WIN-1-c][r*DWIDTH +: DWIDTH];
    for (int k = 0; k < NTAPS; k++)
      tap_vec[k*DWIDTH +: DWIDTH] = wt_q[k];
  end

  conv2d_mac9 #(
    .DWIDTH (DWIDTH),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock        (clock),
    .reset        (reset),
    .en           (advance),
    .in_valid     (v0_q),
    .win_px       (win_px),
    .taps         (tap_vec),
    .bias         (wt_q[BIAS_ADDR]),
    .stage1_valid (mac_v1),
    .sum_valid    (mac_v2),
    .sum          (mac_sum)
  );

  assign shifted = mac_sum >>> FRAC;
  assign sat_val = sat_relu({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted}, DWIDTH, relu_q);

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    v0_d        = v0_q;
    wt_d        = wt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (start_frame) begin
      col_d = '0;
      row_d = '0;
    end
    if (pop) begin
      win_d[2] = win_q[1];
      win_d[1] = win_q[0];
      win_d[0] = ff_rdata;
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (advance) begin
      v0_d        = pop & (col_q >= CW'(2));
      out_valid_d = mac_v2;
      if (mac_v2) out_d = sat_val[DWIDTH-1:0];
    end
    if ((state_q == S_IDLE) && wt_we)
      for (int k = 0; k <= BIAS_ADDR; k++)
        if (wt_addr == 4'(k)) wt_d[k] = wt_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '{default: '0};
      v0_q        <= 1'b0;
      wt_q        <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      v0_q        <= v0_d;
      wt_q        <= wt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ff_rdreq = pop;
  assign ff_wrreq = out_valid_q & ~ff_full;
  assign ff_wdata = out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_core_featuremap_conv2d_param.sv
// Self-checking bench: constant vector table, backpressure and reset sequences, random frames vs model.
module tb_core_featuremap_conv2d_param;

  localparam int DW   = 32;
  localparam int FR   = 16;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NOUT = (W - 2) * H;

  logic              clock = 1'b0;
  logic              reset;
  logic [3*DW-1:0]   ff_rdata;
  logic              ff_rdreq;
  logic              ff_empty;
  logic [DW-1:0]     ff_wdata;
  logic              ff_wrreq;
  logic              ff_full;
  logic              wt_we;
  logic [3:0]        wt_addr;
  logic [DW-1:0]     wt_wdata;
  logic              relu_en;
  logic              start;
  logic              busy;
  logic              done;

  always #5 clock = ~clock;

  core_featuremap_conv2d_param #(
    .DWIDTH (DW),
    .FRAC   (FR),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ff_rdata (ff_rdata),
    .ff_rdreq (ff_rdreq),
    .ff_empty (ff_empty),
    .ff_wdata (ff_wdata),
    .ff_wrreq (ff_wrreq),
    .ff_full  (ff_full),
    .wt_we    (wt_we),
    .wt_addr  (wt_addr),
    .wt_wdata (wt_wdata),
    .relu_en  (relu_en),
    .start    (start),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [8:0][DW-1:0] taps;
    logic [DW-1:0]      bias;
    logic               relu;
    logic [DW-1:0]      fill;
    logic               ramp;
    logic [DW-1:0]      e0;
    logic [DW-1:0]      e1;
  } vec_t;

  vec_t            tbl [6];
  logic [3*DW-1:0] in_q  [$];
  logic [3*DW-1:0] frame [$];
  logic [DW-1:0]   got   [$];
  logic [DW-1:0]   expq  [$];
  logic [DW-1:0]   mw    [10];
  logic            mrelu;
  bit              stall_in, full_in, viol;
  logic            s_rd, s_wr, s_done, s_busy;
  logic [DW-1:0]   s_wd;
  int              n_chk = 0;
  int              n_pass = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive_inputs();
    ff_empty = stall_in || (in_q.size() == 0);
    ff_rdata = (in_q.size() != 0) ? in_q[0] : '0;
    ff_full  = full_in;
  endtask

  // Inputs settle at edge+1, handshakes are sampled at edge+2, FIFO models update after the edge.
  task automatic cycle();
    drive_inputs();
    #1;
    s_rd   = ff_rdreq;
    s_wr   = ff_wrreq;
    s_wd   = ff_wdata;
    s_done = done;
    s_busy = busy;
    if ((ff_full && s_wr) || (ff_empty && s_rd)) viol = 1'b1;
    @(posedge clock);
    #1;
    if (s_rd && in_q.size() != 0) void'(in_q.pop_front());
    if (s_wr) got.push_back(s_wd);
  endtask

  task automatic wt_write(input logic [3:0] a, input logic [DW-1:0] d);
    wt_we = 1'b1; wt_addr = a; wt_wdata = d;
    cycle();
    wt_we = 1'b0;
  endtask

  task automatic start_only(input logic r);
    start = 1'b1; relu_en = r;
    cycle();
    start = 1'b0; relu_en = 1'b0;
  endtask

  task automatic load_and_start(input bit same_cycle, input logic r);
    for (int i = 0; i < 9; i++) wt_write(4'(i), mw[i]);
    wt_write(4'(10 + $urandom_range(0, 5)), $urandom());
    wt_we = 1'b1; wt_addr = 4'd9; wt_wdata = mw[9];
    if (same_cycle) begin
      start = 1'b1; relu_en = r;
    end
    cycle();
    wt_we = 1'b0; start = 1'b0; relu_en = 1'b0;
    if (!same_cycle) start_only(r);
  endtask

  function automatic logic signed [127:0] sx(input logic [DW-1:0] v);
    return {{(128-DW){v[DW-1]}}, v};
  endfunction

  task automatic build_expected();
    logic signed [127:0] acc, hi, lo;
    logic [3*DW-1:0]     col;
    expq.delete();
    hi = (128'sd1 <<< (DW - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    for (int s = 0; s < H; s++)
      for (int x = 0; x <= W - 3; x++) begin
        acc = sx(mw[9]) * (128'sd1 <<< FR);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            col = frame[s*W + x + c];
            acc += sx(col[r*DW +: DW]) * sx(mw[r*3 + c]);
          end
        acc = acc >>> FR;
        if (acc > hi) acc = hi;
        else if (acc < lo) acc = lo;
        if (mrelu && acc < 0) acc = 0;
        expq.push_back(acc[DW-1:0]);
      end
  endtask

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] v;
    v = $urandom();
    if ($urandom_range(0, 3) != 0) v = {{(DW-19){v[18]}}, v[18:0]};
    return v;
  endfunction

  task automatic run_frame(input string tag, input bit rnd);
    int dcnt;
    dcnt = 0;
    viol = 1'b0;
    got.delete();
    for (int c = 0; c < 600; c++) begin
      if (rnd) begin
        stall_in = ($urandom_range(0, 2) == 0);
        full_in  = ($urandom_range(0, 2) == 0);
        wt_we    = ($urandom_range(0, 5) == 0);
        wt_addr  = 4'($urandom_range(0, 15));
        wt_wdata = $urandom();
        start    = ($urandom_range(0, 9) == 0);
      end
      cycle();
      if (s_done) begin
        dcnt++;
        break;
      end
    end
    stall_in = 1'b0; full_in = 1'b0; wt_we = 1'b0; start = 1'b0;
    chk({tag, "_done_pulse"}, DW'(dcnt), 1);
    cycle();
    chk({tag, "_done_width"}, DW'(s_done), 0);
    chk({tag, "_busy_after"}, DW'(s_busy), 0);
    chk({tag, "_nout"}, DW'(got.size()), NOUT);
    chk({tag, "_in_drained"}, DW'(in_q.size()), 0);
    chk({tag, "_handshake_rules"}, DW'(viol), 0);
  endtask

  task automatic cmp_outputs(input string tag);
    logic [DW-1:0] a;
    for (int i = 0; i < NOUT; i++) begin
      a = (i < got.size()) ? got[i] : ~expq[i];
      chk($sformatf("%s_out%0d", tag, i), a, expq[i]);
    end
  endtask

  task automatic make_frame(input logic [DW-1:0] fill, input logic ramp);
    logic [DW-1:0] mid;
    frame.delete();
    for (int s = 0; s < H; s++)
      for (int x = 0; x < W; x++) begin
        mid = ramp ? DW'((x + 1) << 16) : fill;
        frame.push_back({fill, mid, fill});
      end
  endtask

  initial begin
    reset = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_wdata = '0;
    relu_en = 1'b0; start = 1'b0; stall_in = 1'b0; full_in = 1'b0; viol = 1'b0;
    drive_inputs();
    repeat (2) cycle();
    chk("rst_rdreq", DW'(ff_rdreq), 0);
    chk("rst_wrreq", DW'(ff_wrreq), 0);
    chk("rst_busy",  DW'(busy), 0);
    chk("rst_done",  DW'(done), 0);
    chk("rst_wdata", ff_wdata, 0);
    reset = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) tbl[i] = '0;
    tbl[0].taps[4] = 32'h0001_0000; tbl[0].ramp = 1'b1;
    tbl[0].e0 = 32'h0002_0000; tbl[0].e1 = 32'h0003_0000;
    for (int k = 0; k < 9; k++) tbl[1].taps[k] = 32'h0001_0000;
    tbl[1].bias = 32'h0000_8000; tbl[1].fill = 32'h0001_0000;
    tbl[1].e0 = 32'h0009_8000; tbl[1].e1 = 32'h0009_8000;
    tbl[2].taps[4] = 32'hFFFF_0000; tbl[2].fill = 32'h0002_0000;
    tbl[2].e0 = 32'hFFFE_0000; tbl[2].e1 = 32'hFFFE_0000;
    tbl[3] = tbl[2]; tbl[3].relu = 1'b1; tbl[3].e0 = '0; tbl[3].e1 = '0;
    for (int k = 0; k < 9; k++) tbl[4].taps[k] = 32'h7FFF_FFFF;
    tbl[4].fill = 32'h7FFF_FFFF; tbl[4].e0 = 32'h7FFF_FFFF; tbl[4].e1 = 32'h7FFF_FFFF;
    for (int k = 0; k < 9; k++) tbl[5].taps[k] = 32'h8000_0000;
    tbl[5].fill = 32'h7FFF_FFFF; tbl[5].e0 = 32'h8000_0000; tbl[5].e1 = 32'h8000_0000;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 9; k++) mw[k] = tbl[i].taps[k];
      mw[9] = tbl[i].bias;
      make_frame(tbl[i].fill, tbl[i].ramp);
      expq.delete();
      for (int j = 0; j < NOUT; j++) expq.push_back((j % 2 == 0) ? tbl[i].e0 : tbl[i].e1);
      foreach (frame[j]) in_q.push_back(frame[j]);
      load_and_start(i % 2 == 1, tbl[i].relu);
      run_frame($sformatf("vec%0d", i), 1'b0);
      cmp_outputs($sformatf("vec%0d", i));
    end

    // Output FIFO full from the start: pipeline fills, then must freeze with the first result held.
    for (int k = 0; k < 10; k++) mw[k] = '0;
    mw[4] = 32'h0001_0000;
    make_frame('0, 1'b1);
    foreach (frame[j]) in_q.push_back(frame[j]);
    full_in = 1'b1;
    load_and_start(1'b0, 1'b0);
    repeat (12) cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk($sformatf("bp_wrreq%0d", c), DW'(s_wr), 0);
      chk($sformatf("bp_rdreq%0d", c), DW'(s_rd), 0);
      chk($sformatf("bp_wdata%0d", c), s_wd, 32'h0002_0000);
    end
    full_in = 1'b0;
    run_frame("bp", 1'b0);
    expq.delete();
    for (int j = 0; j < NOUT; j++) expq.push_back((j % 2 == 0) ? 32'h0002_0000 : 32'h0003_0000);
    cmp_outputs("bp");

    for (int f = 0; f < 8; f++) begin
      logic r;
      for (int k = 0; k < 10; k++) mw[k] = rnd_val();
      frame.delete();
      for (int j = 0; j < W * H; j++) frame.push_back({rnd_val(), rnd_val(), rnd_val()});
      r = 1'($urandom_range(0, 1));
      mrelu = r;
      build_expected();
      foreach (frame[j]) in_q.push_back(frame[j]);
      load_and_start(f % 2 == 0, r);
      run_frame($sformatf("rnd%0d", f), 1'b1);
      cmp_outputs($sformatf("rnd%0d", f));
    end

    // Reset in the middle of a frame, then a frame with no weight reload must yield zeros.
    for (int k = 0; k < 10; k++) mw[k] = rnd_val() | 32'h0001_0000;
    frame.delete();
    for (int j = 0; j < W * H; j++) frame.push_back({rnd_val(), rnd_val(), rnd_val()});
    foreach (frame[j]) in_q.push_back(frame[j]);
    load_and_start(1'b0, 1'b0);
    repeat (6) cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_wrreq", DW'(ff_wrreq), 0);
    chk("mid_rst_rdreq", DW'(ff_rdreq), 0);
    chk("mid_rst_busy",  DW'(busy), 0);
    chk("mid_rst_done",  DW'(done), 0);
    chk("mid_rst_wdata", ff_wdata, 0);
    @(posedge clock);
    #1;
    in_q.delete();
    got.delete();
    viol = 1'b0;
    repeat (2) cycle();
    chk("mid_rst_no_write", DW'(got.size()), 0);
    reset = 1'b1;
    cycle();
    frame.delete();
    for (int j = 0; j < W * H; j++) frame.push_back({rnd_val(), rnd_val(), rnd_val()});
    foreach (frame[j]) in_q.push_back(frame[j]);
    start_only(1'b0);
    run_frame("post_rst", 1'b0);
    expq.delete();
    for (int j = 0; j < NOUT; j++) expq.push_back('0);
    cmp_outputs("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
